// File: rtl/aqalu_display_pkg.sv
// Shared types, constants and helpers for the ALU result display stage:
// converter states, active-low 7-segment codes and the BCD add-3 step.
package aqalu_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 12;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // Pre-shift correction: any digit of 5 or more would overflow past 9 once doubled.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] work);
    logic [BCD_W-1:0] adj;
    adj = work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 converter: 8-bit binary to 3-digit BCD, one bit per
// clock, result registered on the 8th shift.
module bin_to_bcd_seq
  import aqalu_display_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             busy,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  conv_state_e      state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [BCD_W-1:0] work_q, work_d;
  logic [BCD_W-1:0] work_adj;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [2:0]       count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    work_d   = work_q;
    count_d  = count_q;
    bcd_d    = bcd_q;
    work_adj = bcd_add3(work_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          work_d  = '0;
          count_d = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {work_d, shift_d} = {work_adj[BCD_W-2:0], shift_q, 1'b0};
        count_d           = count_q + 3'd1;
        if (count_q == 3'd7) begin
          bcd_d   = {work_adj[BCD_W-2:0], shift_q[7]};
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      count_q <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q == CONV);
  assign done = (state_q == CONV) && (count_q == 3'd7);
  assign bcd  = bcd_q;

endmodule

// File: rtl/aqalu_result_display.sv
// Board-facing output stage for the ALU result: decimal (via bin_to_bcd_seq) or
// hex digits on a 3-digit multiplexed common-anode 7-segment display.
module aqalu_result_display
  import aqalu_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            result,
  input  logic                  mode_hex,
  output logic [BCD_W-1:0]      bcd,
  output logic                  busy,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int              CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [7:0]            last_value_q;
  logic                  start;
  logic                  conv_done_unused;
  logic [CNT_W-1:0]      refresh_q, refresh_d;
  logic [1:0]            digit_q, digit_d;
  logic [3:0]            nibble;
  logic                  blank;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Retriggers as soon as the converter idles, so the settled result is always shown.
  assign start = (result != last_value_q) && !busy;

  bin_to_bcd_seq u_bin_to_bcd (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (result),
    .busy  (busy),
    .bcd   (bcd),
    .done  (conv_done_unused)
  );

  always_comb begin
    refresh_d = (refresh_q == CNT_MAX) ? '0 : refresh_q + CNT_W'(1);
    digit_d   = digit_q;
    if (refresh_q == CNT_MAX) begin
      digit_d = (digit_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : digit_q + 2'd1;
    end
  end

  // Leading-zero blanking applies to decimal only; hex shows both nibbles always.
  always_comb begin
    nibble = '0;
    blank  = 1'b1;
    an_d   = '1;
    case (digit_q)
      2'd0: begin
        an_d   = 3'b110;
        nibble = mode_hex ? last_value_q[3:0] : bcd[3:0];
        blank  = 1'b0;
      end
      2'd1: begin
        an_d   = 3'b101;
        nibble = mode_hex ? last_value_q[7:4] : bcd[7:4];
        blank  = !mode_hex && (bcd[11:4] == 8'd0);
      end
      2'd2: begin
        an_d   = 3'b011;
        nibble = bcd[11:8];
        blank  = mode_hex || (bcd[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg_d = blank ? SEG_BLANK : seg_encode(nibble);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_value_q <= '0;
      refresh_q    <= '0;
      digit_q      <= '0;
      seg_n        <= SEG_BLANK;
      an_n         <= '1;
    end else begin
      if (start) last_value_q <= result;
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      seg_n     <= seg_d;
      an_n      <= an_d;
    end
  end

endmodule

// File: tb/tb_aqalu_result_display.sv
// Self-checking bench for aqalu_result_display: scoreboard of expected BCD
// values plus cycle-exact latency, scan-order and segment checks.
module tb_aqalu_result_display;

  localparam int DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SBL = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  result;
  logic        mode_hex;
  logic [11:0] bcd;
  logic        busy;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] sb_q[$];

  aqalu_result_display #(.REFRESH_DIV(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .result   (result),
    .mode_hex (mode_hex),
    .bcd      (bcd),
    .busy     (busy),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every completed conversion pops one expected value.
  initial begin : sb_monitor
    logic prev_busy;
    logic [11:0] exp_v;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_conv", 32'd1, 32'd0);
          end else begin
            exp_v = sb_q.pop_front();
            check("sb_bcd", bcd, exp_v);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_done(input string tag);
    bit seen, fin;
    seen = 0;
    fin  = 0;
    for (int i = 0; i < 30 && !fin; i++) begin
      @(negedge clock);
      if (busy) seen = 1;
      else if (seen) fin = 1;
    end
    check({tag, "_done"}, 32'(fin), 32'd1);
  endtask

  // Aligns to the start of a scan frame then checks 4 cycles per digit.
  task automatic scan_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2);
    logic [2:0] prev;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    bit found;
    prev  = an_n;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (an_n == 3'b110 && prev != 3'b110) found = 1;
      else prev = an_n;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
    for (int d = 0; d < 3; d++) begin
      exp_an  = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
      exp_seg = (d == 0) ? s0 : (d == 1) ? s1 : s2;
      for (int k = 0; k < DIV; k++) begin
        if (d != 0 || k != 0) @(negedge clock);
        check($sformatf("%s_an_d%0d_c%0d", tag, d, k), an_n, exp_an);
        check($sformatf("%s_seg_d%0d_c%0d", tag, d, k), seg_n, exp_seg);
      end
    end
  endtask

  initial begin : stimulus
    int n_busy;
    logic [17:0] pat;

    // Reset state and first conversion latency.
    reset    = 1'b0;
    result   = 8'd200;
    mode_hex = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_seg_n", seg_n, 7'h7F);
    check("rst_an_n", an_n, 3'b111);
    check("rst_bcd", bcd, 12'h000);
    check("rst_busy", busy, 1'b0);

    sb_q.push_back(12'h200);
    reset  = 1'b1;
    n_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check("first_edge_an_n", an_n, 3'b110);
        check("first_edge_capture", busy, 1'b1);
      end
      if (busy) n_busy++;
    end
    check("busy_len_200", n_busy, 8);
    check("bcd_before_8th", bcd, 12'h000);
    @(negedge clock);
    check("busy_after_8th", busy, 1'b0);
    check("bcd_200", bcd, 12'h200);

    // 255 in decimal: scan order and per-digit codes.
    result = 8'd255;
    sb_q.push_back(12'h255);
    wait_done("conv255");
    check("bcd_255", bcd, 12'h255);
    scan_frame("dec255", S5, S5, S2);

    // Leading-zero blanking.
    result = 8'd7;
    sb_q.push_back(12'h007);
    wait_done("conv7");
    scan_frame("dec7", S7, SBL, SBL);
    result = 8'd0;
    sb_q.push_back(12'h000);
    wait_done("conv0");
    scan_frame("dec0", S0, SBL, SBL);

    // Hex pass-through then back to decimal without a new conversion.
    mode_hex = 1'b1;
    result   = 8'hAF;
    sb_q.push_back(12'h175);
    wait_done("convAF");
    scan_frame("hexAF", SF, SA, SBL);
    mode_hex = 1'b0;
    scan_frame("dec175", S5, S7, S1);

    // Change during conversion: finish 10, one idle cycle, then convert 99.
    result = 8'd10;
    sb_q.push_back(12'h010);
    sb_q.push_back(12'h099);
    pat = '0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      pat = {pat[16:0], busy};
      if (i == 2) result = 8'd99;
      if (i == 8) check("bcd_010", bcd, 12'h010);
      if (i == 17) check("bcd_099", bcd, 12'h099);
    end
    check("busy_pattern_10_99", pat, 18'b11111111_0_11111111_0);

    // Reset on the 5th conversion cycle of 128.
    result = 8'd128;
    sb_q.push_back(12'h128);
    for (int i = 0; i < 5; i++) @(negedge clock);
    check("busy_5th_cycle", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_bcd", bcd, 12'h000);
    check("abort_busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (i == 0) check("recapture_busy", busy, 1'b1);
      if (i == 7) check("bcd_before_9th", bcd, 12'h000);
      if (i == 8) check("bcd_128", bcd, 12'h128);
    end

    repeat (2) @(negedge clock);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aqalu_result_display.md
Name: aqalu_result_display

Overview:
Downstream consumer of the ALU's 8-bit result. It converts the result to 3-digit decimal BCD with a sequential shift-add-3 converter, or passes it through as 2-digit hex. It drives a 3-digit multiplexed common-anode 7-segment display on the board. It is the board-facing output stage behind the ALU.

Parameters:
REFRESH_DIV, 50_000, clock cycles each digit stays enabled (1 kHz per digit at 50 MHz); legal range is 2 or more.

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
result  input  8  ALU result, combinational and unsynchronised to any strobe
mode_hex  input  1  0 = decimal display, 1 = hex display
bcd  output  12  registered BCD {hundreds,tens,ones} of the last converted value
busy  output  1  high while a conversion is in progress
seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
an_n  output  3  digit enables, [0]=ones, [2]=hundreds; active-low, one-hot-low, registered

Behaviour:
- Reset (reset=0, async), all registers are cleared:
  - state=IDLE, last_value=0, bcd=12'h000, busy=0
  - seg_n=7'h7F, an_n=3'b111, digit index=0, refresh counter=0
- Converter FSM, states IDLE and CONV:
  - IDLE, at a rising edge with result != last_value:
    - capture result into the shift register and into last_value
    - clear the BCD work register, set count=0, go to CONV, set busy=1
  - CONV, each edge:
    - add 3 to every BCD nibble of the work register that is 5 or more
    - then shift {work, shift} left by 1
    - count++
  - On the edge where count==7 (the 8th shift): bcd <= final work value, go to IDLE, busy=0.
  - Latency: bcd updates exactly 8 edges after the capture edge; busy is high for exactly 8 cycles.
  - Result changes during CONV are ignored. On return to IDLE the comparison against last_value re-triggers, so the final settled value is always converted.
  - Back-to-back changes: a new capture can occur on the first IDLE edge, so the capture interval is 9 cycles at minimum.
- Scanner:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, digit index advances 0→1→2→0.
  - an_n and seg_n are registered from the current index. The first edge after reset release drives an_n=3'b110.
- Digit content, decimal mode (mode_hex=0):
  - digits come from bcd
  - hundreds is blank when it is 0
  - tens is blank when hundreds and tens are both 0
  - ones is always shown
- Digit content, hex mode (mode_hex=1):
  - digit0 = last_value[3:0], digit1 = last_value[7:4], digit2 blank
  - no leading-zero blanking
  - conversion still runs but does not affect hex output
- A mode_hex change takes effect on the next registered seg_n update with no conversion needed.
- Segment codes (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Reset asserted mid-conversion aborts it immediately: bcd returns to 0 and busy=0. After release, a nonzero result is recaptured on the first edge.

Decomposition:
- Package aqalu_display_pkg holds:
  - the state enum (IDLE, CONV)
  - the 16 hex segment constants and SEG_BLANK
  - the digit-count constant (3)
  - the BCD width constant (12)
- One sub-module, bin_to_bcd_seq, contains the converter FSM. Its ports are clock, reset, start, bin[7:0], busy, bcd[11:0], done.
- Scanner, blanking and segment encoding stay in the top module.

Test Plan:
- Hold reset=0 with result=8'd200. Required: seg_n=7'h7F, an_n=3'b111, bcd=0, busy=0. Release reset. Required: capture on the first edge, busy high for 8 cycles, bcd=12'h200 on the 8th edge after capture.
- result=8'd255, mode_hex=0, REFRESH_DIV=4. Required: bcd=12'h255. an_n sequence is 110,101,011 with each step lasting 4 cycles. seg_n shows 5 (0010010), 5, then 2 (0100100).
- result=8'd7. Required: hundreds and tens show 1111111, ones shows 1111000. For result=8'd0, ones shows 1000000 and the other digits are blank.
- mode_hex=1, result=8'hAF. Required: ones=0001110, tens=0001000, hundreds blank. Switching mode_hex to 0 then shows 175.
- Change result 8'd10→8'd99 on the 3rd cycle of busy. Required: bcd=12'h010 first, then an automatic re-conversion to 12'h099. busy stays high for 8+8 cycles with a single idle cycle between.
- Assert reset on the 5th conversion cycle of 8'd128. Required: bcd=0 and busy=0 asynchronously. After release, 12'h128 appears 9 edges later (1 capture edge plus 8 conversion edges).
